// File: rtl/imm_instr_packer.sv
// Packs sign-extended immediates plus register/opcode fields into RISC-V
// I/S/B/J instruction words and streams them into imem through a 2-stage pipeline.
module imm_instr_packer #(
  parameter int WIDTH     = 32,
  parameter int ADDR_W    = 32,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        imm_src,
  input  logic [WIDTH-1:0]  imm,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       err_index,
  output logic [1:0]        state_dbg
);

  // Handshake: a bundle transfers on a rising clk edge where in_valid & in_ready
  // are both high; in_ready is a function of registered state only.

  localparam int CW = $clog2(MAX_WORDS) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(MAX_WORDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_ERROR = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [CW-1:0]     word_cnt;
  logic [CW-1:0]     acc_cnt;
  logic              term_seen;
  logic              s1_valid;
  logic              s1_fail;
  logic              s1_final;
  logic [31:0]       s1_word;
  logic [15:0]       err_idx_q;

  logic        accept;
  logic        wr;
  logic        fits;
  logic        is_final;
  logic [31:0] packed_word;

  assign in_ready = (state == S_RUN) && !term_seen;
  assign accept   = in_valid && in_ready;
  assign is_final = in_last || (acc_cnt == LAST_IDX);
  assign wr       = s1_valid && !s1_fail;

  // Range check: every bit above the field MSB must replicate that MSB.
  always_comb begin
    packed_word = 32'h0;
    fits        = 1'b0;
    unique case (imm_src)
      2'b00: begin
        packed_word = {imm[11:0], rs1, funct3, rd, opcode};
        fits        = (&imm[WIDTH-1:11]) || !(|imm[WIDTH-1:11]);
      end
      2'b01: begin
        packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        fits        = (&imm[WIDTH-1:11]) || !(|imm[WIDTH-1:11]);
      end
      2'b10: begin
        packed_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        fits        = ((&imm[WIDTH-1:12]) || !(|imm[WIDTH-1:12])) && !imm[0];
      end
      2'b11: begin
        packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        fits        = ((&imm[WIDTH-1:20]) || !(|imm[WIDTH-1:20])) && !imm[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr_cnt  <= '0;
      word_cnt  <= '0;
      acc_cnt   <= '0;
      term_seen <= 1'b0;
      s1_valid  <= 1'b0;
      s1_fail   <= 1'b0;
      s1_final  <= 1'b0;
      s1_word   <= 32'h0;
      err_idx_q <= 16'h0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_word  <= packed_word;
        s1_fail  <= !fits;
        s1_final <= is_final;
        acc_cnt  <= acc_cnt + 1'b1;
        if (is_final || !fits)
          term_seen <= 1'b1;
      end
      if (wr) begin
        addr_cnt <= addr_cnt + ADDR_W'(4);
        word_cnt <= word_cnt + 1'b1;
      end
      if (s1_valid && s1_fail)
        err_idx_q <= 16'(word_cnt);

      case (state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            state     <= S_RUN;
            addr_cnt  <= base_addr;
            word_cnt  <= '0;
            acc_cnt   <= '0;
            term_seen <= 1'b0;
            err_idx_q <= 16'h0;
          end
        end
        S_RUN: begin
          if (wr && s1_final)
            state <= S_IDLE;
          else if (s1_valid && s1_fail)
            state <= S_ERROR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_we    = wr;
  assign imem_addr  = addr_cnt;
  assign imem_wdata = s1_word;
  assign done       = wr && s1_final;
  assign err        = s1_valid && s1_fail;
  assign err_index  = err ? 16'(word_cnt) : err_idx_q;
  assign busy       = (state == S_RUN);
  assign state_dbg  = state;

endmodule

// File: tb/tb_imm_instr_packer.sv
// Scoreboard bench for imm_instr_packer: each accepted bundle pushes its expected
// write or error record; the output monitor pops and compares.
module tb_imm_instr_packer;

  localparam int MAXW = 4;
  localparam int RW   = 82;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [1:0]  imm_src;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done, err;
  logic [15:0] err_index;
  logic [1:0]  state_dbg;

  imm_instr_packer #(.WIDTH(32), .ADDR_W(32), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .imm_src(imm_src), .imm(imm), .opcode(opcode), .funct3(funct3),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err),
    .err_index(err_index), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // record: {is_err, done, err_index[15:0], addr[31:0], data[31:0]}
  logic [RW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_addr;
  int          exp_idx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [31:0] pack(input logic [1:0] src, input logic [31:0] v,
                                       input logic [6:0] op, input logic [2:0] f3,
                                       input logic [4:0] d, input logic [4:0] s1,
                                       input logic [4:0] s2);
    logic [31:0] w;
    w = 32'h0;
    w[6:0] = op;
    case (src)
      2'b00: begin w[11:7] = d; w[14:12] = f3; w[19:15] = s1; w[31:20] = v[11:0]; end
      2'b01: begin w[11:7] = v[4:0]; w[14:12] = f3; w[19:15] = s1; w[24:20] = s2; w[31:25] = v[11:5]; end
      2'b10: begin w[7] = v[11]; w[11:8] = v[4:1]; w[14:12] = f3; w[19:15] = s1; w[24:20] = s2;
                   w[30:25] = v[10:5]; w[31] = v[12]; end
      default: begin w[11:7] = d; w[19:12] = v[19:12]; w[20] = v[11]; w[30:21] = v[10:1]; w[31] = v[20]; end
    endcase
    return w;
  endfunction

  function automatic bit legal(input logic [1:0] src, input logic [31:0] v);
    int s;
    s = $signed(v);
    case (src)
      2'b00, 2'b01: return (s >= -2048) && (s <= 2047);
      2'b10:        return (s >= -4096) && (s <= 4094) && (v[0] == 1'b0);
      default:      return (s >= -1048576) && (s <= 1048574) && (v[0] == 1'b0);
    endcase
  endfunction

  // output monitor
  always @(negedge clk) begin
    logic [RW-1:0] r;
    if (imem_we || err || done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {61'h0, imem_we, err, done}, 64'h0);
      end else begin
        r = exp_q.pop_front();
        check("err", err, r[81]);
        check("we", imem_we, !r[81]);
        check("done", done, r[80]);
        if (r[81]) check("err_index", err_index, r[79:64]);
        else begin
          check("addr", imem_addr, r[63:32]);
          check("wdata", imem_wdata, r[31:0]);
        end
      end
    end
  end

  task automatic do_start(input logic [31:0] b);
    base_addr = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = b;
    exp_idx  = 0;
  endtask

  task automatic send(input logic [1:0] src, input logic [31:0] v, input logic [6:0] op,
                      input logic [2:0] f3, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic last);
    bit ok;
    bit fin;
    ok = 0;
    imm_src = src; imm = v; opcode = op; funct3 = f3;
    rd = d; rs1 = s1; rs2 = s2; in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else if (legal(src, v)) begin
      fin = last || (exp_idx == MAXW - 1);
      exp_q.push_back({1'b0, fin, 16'h0, exp_addr, pack(src, v, op, f3, d, s1, s2)});
      exp_addr = exp_addr + 4;
      exp_idx++;
    end else begin
      exp_q.push_back({1'b1, 1'b0, 16'(exp_idx), 64'h0});
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_imm(input logic [1:0] src);
    int v;
    case (src)
      2'b00, 2'b01: v = int'($urandom_range(0, 4095)) - 2048;
      2'b10:        v = (int'($urandom_range(0, 4095)) - 2048) * 2;
      default:      v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
    endcase
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = 0; in_valid = 1'b0; in_last = 1'b0;
    imm_src = 0; imm = 0; opcode = 0; funct3 = 0; rd = 0; rs1 = 0; rs2 = 0;
    exp_addr = 0; exp_idx = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_we", imem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_err_index", err_index, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single I, last
    do_start(32'h100);
    send(2'b00, 5, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 1'b1);
    in_valid = 1'b0;
    drain();

    // back-to-back S, B, J
    do_start(32'h0);
    send(2'b01, 8, 7'h23, 3'd2, 5'd0, 5'd0, 5'd2, 1'b0);
    send(2'b10, -4, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    send(2'b11, 8, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    in_valid = 1'b0;
    drain();

    // misaligned B as bundle 2, then restart
    do_start(32'h200);
    send(2'b00, 1, 7'h13, 3'd0, 5'd3, 5'd4, 5'd0, 1'b0);
    send(2'b00, 2, 7'h13, 3'd0, 5'd3, 5'd4, 5'd0, 1'b0);
    send(2'b10, 3, 7'h63, 3'd1, 5'd0, 5'd5, 5'd6, 1'b0);
    in_valid = 1'b1;
    drain();
    @(negedge clk);
    check("err_ready", in_ready, 0);
    check("err_busy", busy, 0);
    check("err_hold", err_index, 2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    do_start(32'h300);
    send(2'b00, 7, 7'h13, 3'd0, 5'd9, 5'd8, 5'd0, 1'b1);
    in_valid = 1'b0;
    drain();

    // I-range boundaries
    do_start(32'h40);
    send(2'b00, 2048, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 1'b0);
    in_valid = 1'b0;
    drain();
    do_start(32'h80);
    send(2'b00, -2048, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 1'b1);
    in_valid = 1'b0;
    drain();

    // word-limit completion with in_valid held high
    do_start(32'h1000);
    for (int i = 0; i < MAXW; i++)
      send(2'(i), rand_imm(2'(i)), 7'h13, 3'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3), 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("max_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    // random legal sessions
    for (int s = 0; s < 4; s++) begin
      do_start($urandom_range(0, 65535) * 4);
      for (int i = 0; i < 3; i++) begin
        logic [1:0] t;
        t = 2'($urandom_range(0, 3));
        send(t, rand_imm(t), 7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             i == 2);
      end
      in_valid = 1'b0;
      drain();
    end

    // reset mid-stream
    do_start(32'h500);
    send(2'b00, 10, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 1'b0);
    send(2'b00, 11, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_we", imem_we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", state_dbg, 0);
    check("mid_rst_addr", imem_addr, 0);
    check("mid_rst_wdata", imem_wdata, 0);
    check("mid_rst_flags", {done, err}, 0);
    check("mid_rst_q", exp_q.size(), 0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imm_instr_packer.md
Name: imm_instr_packer

Overview:
- Inverse of the immediate extender: takes a sign-extended immediate plus register and opcode fields, and scatters the immediate back into RISC-V I/S/B/J instruction bit positions.
- Range- and alignment-checks each immediate before encoding.
- Streams the packed words into instruction memory through a 2-stage valid/ready pipeline.
- Used as the program loader / self-test word generator feeding imem in the Single_Cycle core.

Parameters:
- WIDTH, 32, width of the incoming immediate. Only 32 is supported.
- ADDR_W, 32, width of the imem byte address.
- MAX_WORDS, 1024, number of words written before automatic completion.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- start  input  1  one-cycle pulse that begins a load session
- base_addr  input  ADDR_W  first imem byte address, sampled on start
- in_valid  input  1  field bundle valid
- in_ready  output  1  packer can accept a bundle this cycle
- in_last  input  1  marks the final bundle of the session
- imm_src  input  2  immediate type: 00=I, 01=S, 10=B, 11=J
- imm  input  WIDTH  sign-extended immediate value
- opcode  input  7  instr[6:0]
- funct3  input  3  instr[14:12] (ignored for J)
- rd  input  5  instr[11:7] (used by I and J)
- rs1  input  5  instr[19:15] (ignored for J)
- rs2  input  5  instr[24:20] (used by S and B)
- imem_we  output  1  write strobe
- imem_addr  output  ADDR_W  write byte address
- imem_wdata  output  32  packed instruction word
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse on successful completion
- err  output  1  one-cycle pulse on range or alignment failure
- err_index  output  16  zero-based bundle number that failed; holds its value until the next start

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; addr counter, word counter, imem_we, imem_addr, imem_wdata, done, err and err_index all return to 0. Reset mid-session aborts the session and writes nothing further.
- FSM states: IDLE, RUN, ERROR.
  - IDLE -> RUN on start. Loads base_addr into the addr counter and clears the word counter.
  - RUN -> IDLE after the write of a bundle tagged in_last, or after the write of word MAX_WORDS-1. done pulses in the same cycle as that final imem_we.
  - RUN -> ERROR when an accepted bundle fails its check.
  - ERROR -> RUN on start (same reload as from IDLE). start is ignored while in RUN.
- in_ready = (state==RUN) and no terminating bundle (last, MAX_WORDS-th, or failing) already accepted. Acceptance = in_valid & in_ready.
- Stage 1, in the acceptance cycle: encode and check the bundle, then register the result.
- Stage 2, the next cycle: imem_we=1 with the registered word at the current addr. The addr counter then increments by 4 and the word counter by 1. Throughput is one word per cycle. imem_we is 0 in every cycle with no stage-2 write.
- Packing:
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Legal ranges:
  - I and S: -2048..2047.
  - B: -4096..4094, imm[0]=0.
  - J: -1048576..1048574, imm[0]=0.
  - Check is signed: upper bits above the field's MSB must all equal that MSB.
- Failing bundle: nothing is written for it (imem_we stays 0). err pulses in stage 2 with err_index = word counter. FSM enters ERROR; in_ready=0 until the next start. Words already written stay valid.
- Address wrap: the addr counter wraps modulo 2^ADDR_W with no flag raised.
- Back-pressure: in_ready does not depend on in_valid, so there is no combinational loop.

Test Plan:
- start with base_addr=0x100, then send I opcode=0x13, funct3=0, rd=1, rs1=0, imm=5 with in_last=1. Expect imem_we one cycle after acceptance with addr 0x100, wdata 0x00500093, and done in the same cycle.
- Stream back-to-back S (sw rs2=2, rs1=0, f3=2, imm=8), B (beq x0,x0, opcode 0x63, imm=-4) and J (jal rd=0, opcode 0x6F, imm=8, last). Expect wdata 0x00202423, 0xFE000EE3, 0x0080006F at addr 0x0, 0x4, 0x8 on consecutive cycles; done with the third write.
- B with imm=3 as bundle 2 (0-based). Expect no write for it, err pulse with err_index=2, in_ready=0. A new start returns to RUN and the next write lands at the new base_addr.
- I with imm=2048. Expect err. I with imm=-2048. Expect wdata[31:20]=0x800 and a write.
- MAX_WORDS=4 with in_valid held high. Expect exactly 4 writes, done on the 4th, in_ready low from the 4th acceptance onward.
- Drive rst_n=0 for one cycle mid-stream. Expect imem_we=0, busy=0, all outputs 0 the next cycle, and no further writes until start.
